mdu_e: RTL
==========

# mdu_e

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It takes the already-forwarded rs/rt operands selected by the E-stage forwarding muxes. It runs multi-cycle signed/unsigned multiply and divide and holds the architectural HI/LO registers. `busy` drives the stall unit, which holds D-stage mult/div/mfhi/mflo/mthi/mtlo instructions until the operation completes.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/maddu when enabled); legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–15.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `start` input 1: E-stage instruction is an MDU op; qualified with `op`.
- `op` input 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- `A` input 32: forwarded rs value (post-FRSE mux).
- `B` input 32: forwarded rt value (post-FRTE mux).
- `busy` output 1: a multi-cycle operation is in flight.
- `HI` output 32: architectural HI, read by mfhi in E.
- `LO` output 32: architectural LO, read by mflo in E.

## Operation
- Two states:
  - IDLE: `busy`=0; accepts `start`.
  - RUN: `busy`=1; a 4-bit down-counter counts remaining cycles.
- IDLE + `start` + op mult/multu/div/divu/madd/maddu:
  - capture the 64-bit result into pending registers `PH`/`PL` in the same edge;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- IDLE + `start` + op mthi/mtlo:
  - write `A` into HI/LO on that edge;
  - no busy, stay IDLE.
- RUN: decrement the counter each edge. On the edge where the counter goes 1→0:
  - write `PH`→HI and `PL`→LO;
  - go to IDLE.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient, HI=remainder. Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - divu: same, unsigned.
- Divide by zero (`B`=0, div/divu): still occupies `DIV_CYCLES` busy cycles, but HI/LO are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- `start` while in RUN is ignored: no restart, no HI/LO write. The stall unit guarantees this never happens legally.
- No flush input. Once started, an operation always commits (delay-slot semantics).

## Timing
- Reset (`reset_n`=0 at an edge): HI=0, LO=0, `busy`=0, counter=0, `PH`/`PL`=0, state IDLE. This applies mid-operation too: the pending result is discarded.
- `start` sampled at edge k with latency N:
  - `busy`=1 after edge k through edge k+N−1, i.e. exactly N cycles high;
  - HI/LO take the new value at edge k+N, the same edge where `busy` falls;
  - an mfhi in E during cycle k+N reads the new value.
- mthi/mtlo: HI/LO update at edge k; visible in cycle k+1.
- Back-to-back: `start` in the cycle right after `busy` falls is accepted (zero bubble).
- `busy` is a registered output with no combinational path from `start`. The stall unit must OR `start`-of-MDU-in-E with `busy`.

## Configuration
- `MDU_MADD_EN` defined:
  - op 110 (madd) computes {HI,LO} + signed(A×B) into `PH`/`PL`, using the HI/LO values at the start edge;
  - op 111 (maddu) does the same unsigned;
  - both use `MULT_CYCLES`.
- `MDU_MADD_EN` undefined:
  - ops 110/111 are treated as no-ops: no busy, HI/LO unchanged;
  - no accumulate adder is synthesized.

## Test plan
- mult A=0xFFFFFFFF, B=0x00000002 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- With HI=0x11, LO=0x22: divu A=5, B=0 → 10 busy cycles, then HI=0x11, LO=0x22 unchanged.
- mthi A=0xDEADBEEF → HI=0xDEADBEEF next cycle, `busy` never asserts. A `start` (mult 3×3) issued mid-RUN of a prior mult 2×2 is ignored: LO=4 at completion.
- mult 3×4 started, `reset_n`=0 on the 3rd busy cycle → next cycle `busy`=0, HI=LO=0, and no later commit of 12.
- `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 → HI=1, LO=0. Without the macro: same stimulus leaves HI=0, LO=0xFFFFFFFF, `busy` stays 0.

Source files
------------

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit holding architectural HI/LO for the 5-stage MIPS pipeline.
// Optional accumulate ops (madd/maddu) are built only when MDU_MADD_EN is defined.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
  localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_ph;
  logic [31:0] r_pl;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_wr;

  state_t      w_state_next;
  logic [3:0]  w_cnt_next;
  logic [31:0] w_ph_next;
  logic [31:0] w_pl_next;
  logic [31:0] w_hi_next;
  logic [31:0] w_lo_next;
  logic        w_wr_next;

  // Multiply: op[0] selects unsigned for mult/multu and madd/maddu alike.
  logic [63:0] w_as;
  logic [63:0] w_bs;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;

  assign w_as     = {{32{A[31]}}, A};
  assign w_bs     = {{32{B[31]}}, B};
  assign w_prod_s = w_as * w_bs;
  assign w_prod_u = {32'd0, A} * {32'd0, B};
  assign w_prod   = op[0] ? w_prod_u : w_prod_s;

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic        w_sdiv;
  logic        w_b_zero;
  logic [31:0] w_ua;
  logic [31:0] w_ub;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_sdiv   = ~op[0];
  assign w_b_zero = (B == 32'd0);
  assign w_ua     = (w_sdiv & A[31]) ? (~A + 32'd1) : A;
  assign w_ub     = w_b_zero ? 32'd1 : ((w_sdiv & B[31]) ? (~B + 32'd1) : B);
  assign w_uq     = w_ua / w_ub;
  assign w_ur     = w_ua % w_ub;
  assign w_quo    = (w_sdiv & (A[31] ^ B[31])) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem    = (w_sdiv & A[31]) ? (~w_ur + 32'd1) : w_ur;

`ifdef MDU_MADD_EN
  logic [63:0] w_macc;
  assign w_macc = {r_hi, r_lo} + w_prod;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ph_next    = r_ph;
    w_pl_next    = r_pl;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_wr_next    = r_wr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: begin
              w_ph_next    = w_prod[63:32];
              w_pl_next    = w_prod[31:0];
              w_cnt_next   = L_MULT;
              w_wr_next    = 1'b1;
              w_state_next = S_RUN;
            end
            3'b010, 3'b011: begin
              w_ph_next    = w_rem;
              w_pl_next    = w_quo;
              w_cnt_next   = L_DIV;
              w_wr_next    = ~w_b_zero;
              w_state_next = S_RUN;
            end
            3'b100: w_hi_next = A;
            3'b101: w_lo_next = A;
`ifdef MDU_MADD_EN
            3'b110, 3'b111: begin
              w_ph_next    = w_macc[63:32];
              w_pl_next    = w_macc[31:0];
              w_cnt_next   = L_MULT;
              w_wr_next    = 1'b1;
              w_state_next = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // start is ignored here; the stall unit never issues one while busy.
        if (r_cnt <= 4'd1) begin
          if (r_wr) begin
            w_hi_next = r_ph;
            w_lo_next = r_pl;
          end
          w_cnt_next   = 4'd0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ph    <= 32'd0;
      r_pl    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ph    <= w_ph_next;
      r_pl    <= w_pl_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_wr    <= w_wr_next;
    end
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
